// File: rtl/mem_io_pkg.sv
// mem_io shared definitions: IO register offsets, STATUS bit positions,
// the address bit that selects the IO region, and the UART TX FSM states.
package mem_io_pkg;

  // bus_addr bit that switches between RAM (0) and the IO region (1)
  localparam int REGION_BIT = 30;

  // IO register offsets (bus_addr[3:0] inside the IO region)
  localparam logic [3:0] IO_TXDATA = 4'd0;
  localparam logic [3:0] IO_STATUS = 4'd1;
  localparam logic [3:0] IO_CYCLE  = 4'd2;

  // STATUS register bit positions
  localparam int STATUS_FULL_BIT  = 0;
  localparam int STATUS_EMPTY_BIT = 1;
  localparam int STATUS_BUSY_BIT  = 2;

  // UART transmitter states
  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/mem_io_uart_tx.sv
// UART 8N1 transmitter with a small byte FIFO in front of it.
// The FIFO pointers carry one wrap bit so full and empty are distinguishable.
// A push to a full FIFO is dropped, even when a pop happens on the same edge.
module mem_io_uart_tx
  import mem_io_pkg::*;
#(
  parameter int UART_DIV   = 434,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] data,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       tx
);

  localparam int FAW = $clog2(FIFO_DEPTH);
  localparam int DW  = (UART_DIV > 2) ? $clog2(UART_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(UART_DIV - 1);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);
  localparam logic [FAW:0]  PTR_ONE  = {{FAW{1'b0}}, 1'b1};
  localparam logic [FAW:0]  FULL_XOR = {1'b1, {FAW{1'b0}}};

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [FAW:0]  wr_ptr_r;
  logic [FAW:0]  rd_ptr_r;
  logic          push_ok_s;
  logic          pop_s;

  tx_state_e     state_r;
  tx_state_e     state_s;
  logic [DW-1:0] div_r;
  logic [DW-1:0] div_s;
  logic [2:0]    bit_r;
  logic [2:0]    bit_s;
  logic [7:0]    shift_r;
  logic [7:0]    shift_s;
  logic          tx_r;
  logic          tx_s;

  assign full      = ((wr_ptr_r ^ rd_ptr_r) == FULL_XOR);
  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign busy      = (state_r != TX_IDLE);
  assign tx        = tx_r;
  // fullness is judged on the pre-edge pointers, before any coincident pop
  assign push_ok_s = push && !full && !reset;

  // FIFO storage: write the pushed byte at the write pointer
  always_ff @(posedge clock) begin
    if (push_ok_s) begin
      fifo_mem[wr_ptr_r[FAW-1:0]] <= data;
    end
  end

  // FIFO pointers: advance on accepted push and on pop
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // TX FSM next state: pop in Idle, then start, 8 data bits LSB first, stop
  always_comb begin
    state_s = state_r;
    div_s   = div_r;
    bit_s   = bit_r;
    shift_s = shift_r;
    tx_s    = tx_r;
    pop_s   = 1'b0;
    case (state_r)
      TX_IDLE: begin
        if (!empty) begin
          pop_s   = 1'b1;
          shift_s = fifo_mem[rd_ptr_r[FAW-1:0]];
          state_s = TX_START;
          div_s   = '0;
          bit_s   = 3'd0;
          tx_s    = 1'b0;
        end else begin
          tx_s    = 1'b1;
        end
      end
      TX_START: begin
        if (div_r == DIV_LAST) begin
          state_s = TX_DATA;
          div_s   = '0;
          bit_s   = 3'd0;
          tx_s    = shift_r[0];
        end else begin
          div_s   = div_r + DIV_ONE;
        end
      end
      TX_DATA: begin
        if (div_r == DIV_LAST) begin
          div_s = '0;
          if (bit_r == 3'd7) begin
            state_s = TX_STOP;
            tx_s    = 1'b1;
          end else begin
            bit_s   = bit_r + 3'd1;
            shift_s = {1'b0, shift_r[7:1]};
            tx_s    = shift_r[1];
          end
        end else begin
          div_s = div_r + DIV_ONE;
        end
      end
      TX_STOP: begin
        if (div_r == DIV_LAST) begin
          state_s = TX_IDLE;
          div_s   = '0;
          tx_s    = 1'b1;
        end else begin
          div_s   = div_r + DIV_ONE;
        end
      end
      default: begin
        state_s = TX_IDLE;
        div_s   = '0;
        bit_s   = 3'd0;
        tx_s    = 1'b1;
      end
    endcase
  end

  // TX FSM registers; reset aborts any frame and returns the line high
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= TX_IDLE;
      div_r   <= '0;
      bit_r   <= 3'd0;
      shift_r <= 8'h00;
      tx_r    <= 1'b1;
    end else begin
      state_r <= state_s;
      div_r   <= div_s;
      bit_r   <= bit_s;
      shift_r <= shift_s;
      tx_r    <= tx_s;
    end
  end

endmodule

// File: rtl/mem_io.sv
// mem_io: word-addressed RAM plus a small IO region (UART TX data, STATUS,
// free-running CYCLE counter). Reads are combinational; writes happen on the
// rising clock edge with per-byte enables.
// Optional feature macro: MEM_IO_CYCLE_COUNTER_EN enables the CYCLE counter;
// without it IO offset 2 reads as zero.
module mem_io
  import mem_io_pkg::*;
#(
  parameter int    RAM_WORDS  = 4096,
  parameter string INIT_FILE  = "",
  parameter int    UART_DIV   = 434,
  parameter int    FIFO_DEPTH = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_data_w,
  input  logic [3:0]  bus_mask_w,
  output logic [31:0] bus_data_r,
  output logic        uart_tx
);

  localparam int RAW = $clog2(RAM_WORDS);

  logic [31:0]    ram_r [RAM_WORDS];
  logic [RAW-1:0] ram_idx_s;
  logic           io_sel_s;
  logic [3:0]     io_off_s;
  logic           push_s;
  logic           full_s;
  logic           empty_s;
  logic           busy_s;
  logic [31:0]    rd_s;
  logic           unused_s;

  assign ram_idx_s = bus_addr[RAW-1:0];
  assign io_sel_s  = bus_addr[REGION_BIT];
  assign io_off_s  = bus_addr[3:0];
  assign unused_s  = ^{bus_addr[31], bus_addr[29:RAW]};

  // RAM write with byte lanes; deliberately independent of reset
  always_ff @(posedge clock) begin
    if (!io_sel_s) begin
      for (int i = 0; i < 4; i++) begin
        if (bus_mask_w[i]) begin
          ram_r[ram_idx_s][8*i +: 8] <= bus_data_w[8*i +: 8];
        end
      end
    end
  end

  // only the low byte lane of a TXDATA write feeds the FIFO, never during reset
  assign push_s = io_sel_s && (io_off_s == IO_TXDATA) && bus_mask_w[0] && !reset;

`ifdef MEM_IO_CYCLE_COUNTER_EN
  logic [31:0] cycle_r;

  // free-running cycle counter, wraps naturally
  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_r <= 32'h0000_0000;
    end else begin
      cycle_r <= cycle_r + 32'd1;
    end
  end
`endif

  mem_io_uart_tx #(
    .UART_DIV   (UART_DIV),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_uart_tx (
    .clock (clock),
    .reset (reset),
    .push  (push_s),
    .data  (bus_data_w[7:0]),
    .full  (full_s),
    .empty (empty_s),
    .busy  (busy_s),
    .tx    (uart_tx)
  );

  // read mux: RAM word or IO register, zero for anything unmapped
  always_comb begin
    rd_s = 32'h0000_0000;
    if (!io_sel_s) begin
      rd_s = ram_r[ram_idx_s];
    end else begin
      case (io_off_s)
        IO_TXDATA: rd_s = 32'h0000_0000;
        IO_STATUS: begin
          rd_s[STATUS_FULL_BIT]  = full_s;
          rd_s[STATUS_EMPTY_BIT] = empty_s;
          rd_s[STATUS_BUSY_BIT]  = busy_s;
        end
`ifdef MEM_IO_CYCLE_COUNTER_EN
        IO_CYCLE:  rd_s = cycle_r;
`else
        IO_CYCLE:  rd_s = 32'h0000_0000;
`endif
        default:   rd_s = 32'h0000_0000;
      endcase
    end
  end

  assign bus_data_r = rd_s;

endmodule

// File: tb/tb_mem_io.sv
// Self-checking bench for mem_io: table-driven bus vectors, hand-written
// UART/reset/counter sequences, and randomized RAM and UART traffic checked
// against a byte-lane memory array and a decoded-frame queue.
module tb_mem_io;

  localparam int RW  = 64;
  localparam int DIV = 4;
  localparam int FD  = 4;
  localparam logic [31:0] IO_BASE = 32'h4000_0000;
  localparam logic [31:0] A_TX    = 32'h4000_0000;
  localparam logic [31:0] A_ST    = 32'h4000_0001;
  localparam logic [31:0] A_CY    = 32'h4000_0002;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] bus_addr;
  logic [31:0] bus_data_w;
  logic [3:0]  bus_mask_w;
  logic [31:0] bus_data_r;
  logic        uart_tx;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [RW];
  logic [7:0]  rx_q [$];
  logic [7:0]  exp_q [$];
  bit          mon_en = 1'b0;
  logic [7:0]  mon_byte;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [13];

  always #5 clock = ~clock;

  mem_io #(
    .RAM_WORDS  (RW),
    .INIT_FILE  (""),
    .UART_DIV   (DIV),
    .FIFO_DEPTH (FD)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .bus_addr   (bus_addr),
    .bus_data_w (bus_data_w),
    .bus_mask_w (bus_mask_w),
    .bus_data_r (bus_data_r),
    .uart_tx    (uart_tx)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    bus_addr   = a;
    bus_data_w = d;
    bus_mask_w = m;
    tick();
    bus_mask_w = 4'h0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    bus_addr   = a;
    bus_mask_w = 4'h0;
    #1;
    d = bus_data_r;
  endtask

  // UART receiver: sample each bit in its middle, collect decoded bytes
  initial begin
    forever begin
      @(negedge clock);
      if (mon_en && !reset && uart_tx == 1'b0) begin
        repeat (DIV + DIV / 2) @(negedge clock);
        mon_byte[0] = uart_tx;
        for (int i = 1; i < 8; i++) begin
          repeat (DIV) @(negedge clock);
          mon_byte[i] = uart_tx;
        end
        repeat (DIV) @(negedge clock);
        check("stop_bit", {31'd0, uart_tx}, 32'd1);
        rx_q.push_back(mon_byte);
      end
    end
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  m;
    logic [7:0]  v;
    int          w;
    int          r;
    int          n;
    bit          low_seen;

    reset      = 1'b1;
    bus_addr   = 32'h0;
    bus_data_w = 32'h0;
    bus_mask_w = 4'h0;
    repeat (3) tick();

    // reset state
    check("rst_tx", {31'd0, uart_tx}, 32'd1);
    bus_read(A_ST, rd);
    check("rst_status", rd, 32'h2);
    bus_read(A_CY, rd);
    check("rst_cycle", rd, 32'h0);
    reset = 1'b0;
    tick();

    // single-cycle bus vectors: write, then read back on the next cycle
    vecs[0]  = '{32'd5,              32'hDEADBEEF, 4'hF, 32'd5,          32'hDEADBEEF};
    vecs[1]  = '{32'd5,              32'h00005500, 4'h2, 32'd5,          32'hDEAD55EF};
    vecs[2]  = '{32'd6,              32'h11223344, 4'hF, 32'd6,          32'h11223344};
    vecs[3]  = '{32'd70,             32'h000000AA, 4'h1, 32'd6,          32'h112233AA};
    vecs[4]  = '{32'h8000_0006,      32'h99000000, 4'h8, 32'd6,          32'h992233AA};
    vecs[5]  = '{32'd63,             32'hCAFEF00D, 4'hF, 32'd63,         32'hCAFEF00D};
    vecs[6]  = '{32'd63,             32'hAB000000, 4'h8, 32'd63,         32'hABFEF00D};
    vecs[7]  = '{32'd63,             32'h00000000, 4'h0, 32'd63,         32'hABFEF00D};
    vecs[8]  = '{IO_BASE + 32'd7,    32'hFFFFFFFF, 4'hF, IO_BASE + 32'd7, 32'h0};
    vecs[9]  = '{A_ST,               32'hFFFFFFFF, 4'hF, A_ST,           32'h2};
    vecs[10] = '{IO_BASE + 32'd15,   32'h12345678, 4'hF, IO_BASE + 32'd15, 32'h0};
    vecs[11] = '{A_CY,               32'hFFFFFFFF, 4'hF, IO_BASE + 32'd5, 32'h0};
    vecs[12] = '{A_TX,               32'h000000FF, 4'h0, A_TX,           32'h0};
    for (int i = 0; i < 13; i++) begin
      bus_write(vecs[i].addr, vecs[i].wdata, vecs[i].mask);
      bus_read(vecs[i].raddr, rd);
      check($sformatf("vec%0d", i), rd, vecs[i].exp);
    end
    tick();
    bus_read(A_ST, rd);
    check("status_after_vecs", rd, 32'h2);
    check("tx_idle_after_vecs", {31'd0, uart_tx}, 32'd1);

    // single frame 0x41: exact waveform and busy flag
    mon_en = 1'b1;
    rx_q.delete();
    bus_write(A_TX, 32'h00000041, 4'h1);
    check("tx_before_start", {31'd0, uart_tx}, 32'd1);
    v = 8'h41;
    for (int i = 0; i < 10 * DIV; i++) begin
      tick();
      if (i / DIV == 0)      d = 32'd0;
      else if (i / DIV == 9) d = 32'd1;
      else                   d = {31'd0, v[i / DIV - 1]};
      check($sformatf("wave%0d", i), {31'd0, uart_tx}, d);
      bus_read(A_ST, rd);
      check($sformatf("busy%0d", i), rd, 32'h6);
    end
    tick();
    bus_read(A_ST, rd);
    check("status_after_frame", rd, 32'h2);
    repeat (4) tick();
    check("rx_41_count", rx_q.size(), 32'd1);
    if (rx_q.size() > 0) check("rx_41_byte", {24'd0, rx_q[0]}, 32'h41);

    // overflow: one in flight plus pushes into a 4-deep FIFO
    rx_q.delete();
    bus_write(A_TX, 32'h00000010, 4'h1);
    tick();
    for (int i = 1; i <= 6; i++) begin
      bus_write(A_TX, 32'h00000010 + i, 4'h1);
      bus_read(A_ST, rd);
      check($sformatf("full_after_push%0d", i), {31'd0, rd[0]}, (i >= 4) ? 32'd1 : 32'd0);
    end
    for (int t = 0; t < 400 && rx_q.size() < 5; t++) tick();
    repeat (60) tick();
    check("ovf_frame_count", rx_q.size(), 32'd5);
    for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
      check($sformatf("ovf_byte%0d", i), {24'd0, rx_q[i]}, 32'h10 + i);
    end

    // randomized bursts against an expected byte queue
    for (int b = 0; b < 3; b++) begin
      rx_q.delete();
      exp_q.delete();
      n = $urandom_range(1, FD);
      for (int j = 0; j < n; j++) begin
        d = $urandom;
        m = 4'($urandom) | 4'h1;
        bus_write(A_TX, d, m);
        exp_q.push_back(d[7:0]);
      end
      for (int t = 0; t < 300 && rx_q.size() < n; t++) tick();
      repeat (10) tick();
      check($sformatf("burst%0d_count", b), rx_q.size(), n);
      for (int j = 0; j < n && j < rx_q.size(); j++) begin
        check($sformatf("burst%0d_byte%0d", b, j), {24'd0, rx_q[j]}, {24'd0, exp_q[j]});
      end
    end

    // writes coincident with reset: RAM updates, FIFO does not
    mon_en = 1'b0;
    reset  = 1'b1;
    bus_write(A_TX, 32'h00000077, 4'hF);
    bus_write(32'd10, 32'h0BADF00D, 4'hF);
    reset = 1'b0;
    tick();
    bus_read(A_ST, rd);
    check("rst_write_status", rd, 32'h2);
    bus_read(32'd10, rd);
    check("rst_write_ram", rd, 32'h0BADF00D);
    check("rst_write_tx", {31'd0, uart_tx}, 32'd1);

    // reset during data bit 3 aborts the frame and drops the queued byte
    bus_write(A_TX, 32'h000000A5, 4'h1);
    bus_write(A_TX, 32'h0000003C, 4'h1);
    repeat (16) tick();
    check("midframe_bit3", {31'd0, uart_tx}, 32'd0);
    reset = 1'b1;
    tick();
    check("midframe_rst_tx", {31'd0, uart_tx}, 32'd1);
    bus_read(A_ST, rd);
    check("midframe_rst_status", rd, 32'h2);
    reset = 1'b0;
    bus_read(32'd5, rd);
    check("midframe_ram5", rd, 32'hDEAD55EF);
    low_seen = 1'b0;
    for (int t = 0; t < 60; t++) begin
      tick();
      if (uart_tx == 1'b0) low_seen = 1'b1;
    end
    check("midframe_no_tx", {31'd0, low_seen}, 32'd0);

    // cycle counter 10 clocks after reset release
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (10) tick();
    bus_read(A_CY, rd);
`ifdef MEM_IO_CYCLE_COUNTER_EN
    check("cycle_10", rd, 32'd10);
    force dut.cycle_r = 32'hFFFF_FFFF;
    #1;
    bus_read(A_CY, rd);
    check("cycle_forced", rd, 32'hFFFF_FFFF);
    release dut.cycle_r;
    tick();
    bus_read(A_CY, rd);
    check("cycle_wrap", rd, 32'h0);
`else
    check("cycle_absent", rd, 32'h0);
    repeat (5) tick();
    bus_read(A_CY, rd);
    check("cycle_absent_later", rd, 32'h0);
`endif

    // randomized RAM traffic with address aliasing and byte masks
    for (int i = 0; i < RW; i++) begin
      d = $urandom;
      bus_write(32'(i), d, 4'hF);
      ref_mem[i] = d;
    end
    for (int k = 0; k < 300; k++) begin
      w = $urandom_range(0, RW - 1);
      d = $urandom;
      m = 4'($urandom);
      a = {1'($urandom), 1'b0, 24'($urandom), 6'(w)};
      bus_write(a, d, m);
      for (int l = 0; l < 4; l++) begin
        if (m[l]) ref_mem[w][8*l +: 8] = d[8*l +: 8];
      end
      r = ($urandom_range(0, 3) == 0) ? w : $urandom_range(0, RW - 1);
      a = {1'($urandom), 1'b0, 24'($urandom), 6'(r)};
      bus_read(a, rd);
      check($sformatf("ram_rand%0d", k), rd, ref_mem[r]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
